// File: rtl/fila_sched.sv
// Transfer scheduler between the deserializer and the fila queue: enqueue/dequeue strobes, round-robin arbitration, own occupancy count.
// Latency: enqueue strobe one cycle after data_ready is sampled in IDLE; dequeue strobe two edges after a dequeue_in rising edge.
// Backpressure: when full, data_ready is not acked; with FILA_SCHED_DROP_EN defined, the word is acked and discarded instead.
module fila_sched #(
  parameter int DEPTH = 8,
  parameter int LEN_W = 8
) (
  input  logic             clk_10KHz,
  input  logic             reset,
  input  logic             data_ready,
  input  logic             dequeue_in,
  output logic             ack_out,
  output logic             enqueue_out,
  output logic             dequeue_out,
  output logic [LEN_W-1:0] len_out,
  output logic             full_out,
  output logic             empty_out
`ifdef FILA_SCHED_DROP_EN
  ,
  output logic [LEN_W-1:0] drop_cnt_out
`endif
);

  typedef enum logic [1:0] {IDLE, ENQ, WAIT_REL, DEQ} state_t;

  state_t           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             ack_q, ack_d;
  logic             enq_q, enq_d;
  logic             deq_q, deq_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             deq_pend_q, deq_pend_d;
  logic             rr_q, rr_d;         // 0: ENQ wins the next tie, 1: DEQ wins
  logic             dq_in_q;            // previous dequeue_in, for edge detection
  logic             deq_rise;
  logic             enq_elig;
  logic             deq_elig;
  logic             grant_enq;
  logic             grant_deq;
`ifdef FILA_SCHED_DROP_EN
  logic [LEN_W-1:0] drop_q, drop_d;
`endif

  assign deq_rise = dequeue_in & ~dq_in_q;
`ifdef FILA_SCHED_DROP_EN
  assign enq_elig = data_ready;
`else
  assign enq_elig = data_ready & ~full_q;
`endif
  assign deq_elig = deq_pend_q & ~empty_q;

  // Next-state, arbitration and registered-output values for the scheduler FSM.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    ack_d      = 1'b0;
    enq_d      = 1'b0;
    deq_d      = 1'b0;
    deq_pend_d = deq_pend_q;
    rr_d       = rr_q;
    grant_enq  = 1'b0;
    grant_deq  = 1'b0;
`ifdef FILA_SCHED_DROP_EN
    drop_d     = drop_q;
`endif
    case (state_q)
      IDLE: begin
        if (enq_elig && deq_elig) begin
          grant_enq = ~rr_q;
          grant_deq = rr_q;
          rr_d      = ~rr_q;
        end else begin
          grant_enq = enq_elig;
          grant_deq = deq_elig;
        end
        // A request against an empty queue is simply discarded.
        if (deq_pend_q && empty_q) begin
          deq_pend_d = 1'b0;
        end
      end
      ENQ: begin
        state_d = WAIT_REL;
        ack_d   = 1'b1;
      end
      WAIT_REL: begin
        if (data_ready) begin
          ack_d = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      DEQ: begin
        state_d    = IDLE;
        deq_pend_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase

    if (grant_enq) begin
      state_d = ENQ;
      ack_d   = 1'b1;
      if (!full_q) begin
        enq_d = 1'b1;
        len_d = len_q + LEN_W'(1);
      end
`ifdef FILA_SCHED_DROP_EN
      else if (drop_q != {LEN_W{1'b1}}) begin
        drop_d = drop_q + LEN_W'(1);
      end
`endif
    end
    if (grant_deq) begin
      state_d = DEQ;
      deq_d   = 1'b1;
      len_d   = len_q - LEN_W'(1);
    end

    // A new edge always wins over a clear so it is never lost.
    if (deq_rise) begin
      deq_pend_d = 1'b1;
    end

    full_d  = (len_d == LEN_W'(DEPTH));
    empty_d = (len_d == '0);
  end

  // State, occupancy and output registers with synchronous reset.
  always_ff @(posedge clk_10KHz) begin
    if (reset) begin
      state_q    <= IDLE;
      len_q      <= '0;
      ack_q      <= 1'b0;
      enq_q      <= 1'b0;
      deq_q      <= 1'b0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      deq_pend_q <= 1'b0;
      rr_q       <= 1'b0;
      dq_in_q    <= 1'b0;
`ifdef FILA_SCHED_DROP_EN
      drop_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      ack_q      <= ack_d;
      enq_q      <= enq_d;
      deq_q      <= deq_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      deq_pend_q <= deq_pend_d;
      rr_q       <= rr_d;
      dq_in_q    <= dequeue_in;
`ifdef FILA_SCHED_DROP_EN
      drop_q     <= drop_d;
`endif
    end
  end

  assign ack_out     = ack_q;
  assign enqueue_out = enq_q;
  assign dequeue_out = deq_q;
  assign len_out     = len_q;
  assign full_out    = full_q;
  assign empty_out   = empty_q;
`ifdef FILA_SCHED_DROP_EN
  assign drop_cnt_out = drop_q;
`endif

endmodule

// File: tb/tb_fila_sched.sv
// Bench for fila_sched: directed scenarios plus random traffic, checked every cycle against a transaction-level model.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// Build with FILA_SCHED_DROP_EN defined to exercise the discard variant.
module tb_fila_sched;
  localparam int DEPTH = 8;
  localparam int LEN_W = 8;
`ifdef FILA_SCHED_DROP_EN
  localparam bit DROP = 1'b1;
`else
  localparam bit DROP = 1'b0;
`endif

  logic             clk_10KHz;
  logic             reset;
  logic             data_ready;
  logic             dequeue_in;
  logic             ack_out;
  logic             enqueue_out;
  logic             dequeue_out;
  logic [LEN_W-1:0] len_out;
  logic             full_out;
  logic             empty_out;
`ifdef FILA_SCHED_DROP_EN
  logic [LEN_W-1:0] drop_cnt_out;
`endif

  fila_sched #(.DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
    .clk_10KHz   (clk_10KHz),
    .reset       (reset),
    .data_ready  (data_ready),
    .dequeue_in  (dequeue_in),
    .ack_out     (ack_out),
    .enqueue_out (enqueue_out),
    .dequeue_out (dequeue_out),
    .len_out     (len_out),
    .full_out    (full_out),
    .empty_out   (empty_out)
`ifdef FILA_SCHED_DROP_EN
    ,
    .drop_cnt_out(drop_cnt_out)
`endif
  );

  initial begin
    clk_10KHz = 1'b0;
    forever #5 clk_10KHz = ~clk_10KHz;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: the scheduler is either free, busy with a word
  // (first ack cycle, then waiting for release), or busy with a dequeue.
  int m_len, m_drop, m_busy;  // m_busy: 0 free, 1 word just taken, 2 word waiting release, 3 dequeue
  bit m_ack, m_enq, m_deq, m_pend, m_deq_turn, m_dq_prev;

  task automatic model_edge(input bit dr, input bit dq, input bit rs);
    bit want_enq, want_deq, take_enq, take_deq;
    m_enq = 0;
    m_deq = 0;
    if (rs) begin
      m_len = 0; m_drop = 0; m_busy = 0; m_ack = 0;
      m_pend = 0; m_deq_turn = 0; m_dq_prev = 0;
      return;
    end
    take_enq = 0;
    take_deq = 0;
    if (m_busy == 0) begin
      want_enq = dr && (DROP || m_len < DEPTH);
      want_deq = m_pend && m_len > 0;
      if (want_enq && want_deq) begin
        take_deq   = m_deq_turn;
        take_enq   = !m_deq_turn;
        m_deq_turn = !m_deq_turn;
      end else begin
        take_enq = want_enq;
        take_deq = want_deq;
      end
      if (m_pend && m_len == 0) m_pend = 0;
      if (take_enq) begin
        m_busy = 1;
        m_ack  = 1;
        if (m_len < DEPTH) begin
          m_len++;
          m_enq = 1;
        end else if (m_drop < (1 << LEN_W) - 1) begin
          m_drop++;
        end
      end else if (take_deq) begin
        m_busy = 3;
        m_deq  = 1;
        m_len--;
      end
    end else if (m_busy == 1) begin
      m_busy = 2;
    end else if (m_busy == 2) begin
      if (!dr) begin
        m_busy = 0;
        m_ack  = 0;
      end
    end else begin
      m_busy = 0;
      m_pend = 0;
    end
    if (dq && !m_dq_prev) m_pend = 1;
    m_dq_prev = dq;
  endtask

  task automatic compare_all();
    check("ack_out", ack_out, m_ack);
    check("enqueue_out", enqueue_out, m_enq);
    check("dequeue_out", dequeue_out, m_deq);
    check("len_out", len_out, m_len);
    check("full_out", full_out, m_len == DEPTH);
    check("empty_out", empty_out, m_len == 0);
`ifdef FILA_SCHED_DROP_EN
    check("drop_cnt_out", drop_cnt_out, m_drop);
`endif
  endtask

  // Deserializer behaviour: hold data_ready until ack seen (plus optional extra cycles), then drop.
  bit des_pending = 0;
  int hold_extra  = 0;
  int n_enq = 0, n_deq = 0, n_ack = 0;
  int strobe_log[$];

  task automatic cycle(input bit dq, input bit rs);
    data_ready = des_pending;
    dequeue_in = dq;
    reset      = rs;
    @(posedge clk_10KHz);
    model_edge(des_pending, dq, rs);
    @(negedge clk_10KHz);
    compare_all();
    if (enqueue_out === 1'b1) begin n_enq++; strobe_log.push_back(1); end
    if (dequeue_out === 1'b1) begin n_deq++; strobe_log.push_back(2); end
    if (ack_out === 1'b1) n_ack++;
    if (rs) begin
      des_pending = 0;
    end else if (des_pending && ack_out === 1'b1) begin
      if (hold_extra > 0) hold_extra--;
      else des_pending = 0;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0);
  endtask

  task automatic send_word();
    des_pending = 1;
    hold_extra  = 0;
    for (int i = 0; i < 40 && des_pending; i++) cycle(0, 0);
    check("send_word_acked", des_pending, 0);
    idle(2);
  endtask

  task automatic deq_one();
    bit seen;
    seen = 0;
    cycle(1, 0);
    for (int i = 0; i < 10 && !seen; i++) begin
      cycle(0, 0);
      seen = (dequeue_out === 1'b1);
    end
    check("deq_one_seen", seen, 1);
    cycle(0, 0);
  endtask

  initial begin
    int a0, e0, d0, lat;
    bit dq, rs;
    int exp_log[8];
    data_ready = 0; dequeue_in = 0; reset = 1;
    m_len = 0; m_drop = 0; m_busy = 0; m_ack = 0; m_enq = 0; m_deq = 0;
    m_pend = 0; m_deq_turn = 0; m_dq_prev = 0;

    // Reset values
    cycle(0, 1);
    cycle(0, 1);
    check("rst_len", len_out, 0);
    check("rst_empty", empty_out, 1);
    check("rst_full", full_out, 0);
    check("rst_ack", ack_out, 0);
    idle(2);

    // Single word then single dequeue
    a0 = n_ack; e0 = n_enq;
    send_word();
    check("sw_ack_cycles", n_ack - a0, 2);
    check("sw_enq_pulses", n_enq - e0, 1);
    check("sw_len", len_out, 1);
    d0 = n_deq; lat = 0;
    cycle(1, 0);
    for (int i = 0; i < 10 && n_deq == d0; i++) begin
      cycle(1, 0);
      lat = i + 2;
    end
    check("sd_latency", lat, 2);
    idle(3);
    check("sd_deq_pulses", n_deq - d0, 1);
    check("sd_len", len_out, 0);

    // Fill to DEPTH
    for (int i = 0; i < DEPTH; i++) send_word();
    check("fill_len", len_out, DEPTH);
    check("fill_full", full_out, 1);

    // Word arriving while full
    a0 = n_ack; e0 = n_enq; d0 = n_deq;
    des_pending = 1; hold_extra = 0;
`ifdef FILA_SCHED_DROP_EN
    idle(4);
    check("drop_ack_cycles", n_ack - a0, 2);
    check("drop_no_enq", n_enq - e0, 0);
    check("drop_cnt", drop_cnt_out, 1);
    check("drop_len", len_out, DEPTH);
`else
    idle(6);
    check("bp_no_ack", n_ack - a0, 0);
    check("bp_len_held", len_out, DEPTH);
    cycle(1, 0);
    idle(10);
    check("bp_enq_after_deq", n_enq - e0, 1);
    check("bp_deq", n_deq - d0, 1);
    check("bp_word_taken", des_pending, 0);
    check("bp_len", len_out, DEPTH);
`endif

    // Drain to 4, then contention
    for (int i = 0; i < 4; i++) deq_one();
    check("drain_len", len_out, 4);
    strobe_log.delete();
    for (int r = 0; r < 2; r++) begin
      des_pending = 1; hold_extra = 0;
      cycle(1, 0);
      idle(5);
    end
    cycle(1, 0);
    des_pending = 1; hold_extra = 0;
    cycle(1, 0);
    idle(5);
    cycle(1, 0);
    des_pending = 1; hold_extra = 0;
    cycle(1, 0);
    idle(6);
    exp_log = '{1, 2, 1, 2, 1, 2, 2, 1};
    check("rr_strobe_count", strobe_log.size(), 8);
    for (int i = 0; i < 8 && i < strobe_log.size(); i++)
      check($sformatf("rr_order_%0d", i), strobe_log[i], exp_log[i]);
    check("rr_len", len_out, 4);

    // Dequeue against empty queue
    for (int i = 0; i < 4; i++) deq_one();
    check("empty_len", len_out, 0);
    d0 = n_deq;
    cycle(1, 0);
    idle(4);
    check("empty_no_deq", n_deq - d0, 0);
    send_word();
    idle(4);
    check("empty_pend_cleared", n_deq - d0, 0);
    check("empty_then_word_len", len_out, 1);

    // Three dequeue edges while a word holds ack
    d0 = n_deq;
    des_pending = 1; hold_extra = 6;
    cycle(0, 0);
    for (int i = 0; i < 6; i++) cycle(i % 2 == 0, 0);
    idle(8);
    check("merge_one_deq", n_deq - d0, 1);
    check("merge_len", len_out, 1);

    // Reset while ack is high
    des_pending = 1; hold_extra = 0;
    cycle(0, 0);
    check("pre_rst_ack", ack_out, 1);
    cycle(1, 1);
    check("mid_rst_ack", ack_out, 0);
    check("mid_rst_len", len_out, 0);
    check("mid_rst_empty", empty_out, 1);
    idle(3);

    // Random traffic
    dq = 0;
    for (int i = 0; i < 1500; i++) begin
      if (!des_pending && ack_out === 1'b0 && $urandom_range(3) == 0) begin
        des_pending = 1;
        hold_extra  = $urandom_range(2);
      end
      if ($urandom_range(2) == 0) dq = ~dq;
      rs = ($urandom_range(299) == 0);
      cycle(dq, rs);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
